// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Frame-synchronous data update, dead-time blanking and leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned CLK_DIV       = 50000,
    parameter int unsigned BLANK_CYCLES  = 8,
    parameter bit          EN_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [3:0]              bcd_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    blank,
    output logic                    frame_done
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] EN_IDLE = {NUM_DIGITS{EN_ACTIVE_LOW}};

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         index_q, index_d;
    logic [DW-1:0]         pend_digits_q, pend_digits_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_lz_q, pend_lz_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [DW-1:0]         disp_digits_q, disp_digits_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic                  disp_lz_q, disp_lz_d;

    logic [3:0]            bcd_q, bcd_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic                  blank_q, blank_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] supp;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  zero_above;

    assign slot_end  = (presc_q == PRESC_MAX);
    assign frame_end = slot_end && (index_q == IDX_MAX);

    // Free-running prescaler and digit index.
    always_comb begin
        presc_d = slot_end ? '0 : presc_q + PW'(1);
        index_d = index_q;
        if (slot_end) begin
            index_d = (index_q == IDX_MAX) ? '0 : index_q + IW'(1);
        end
    end

    // Loads queue into pending; display takes pending (or a same-cycle load) at frame end.
    always_comb begin
        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_lz_d     = pend_lz_q;
        pend_valid_d  = pend_valid_q;
        disp_digits_d = disp_digits_q;
        disp_dp_d     = disp_dp_q;
        disp_lz_d     = disp_lz_q;
        if (frame_end) begin
            pend_valid_d = 1'b0;
            if (load) begin
                disp_digits_d = digits_in;
                disp_dp_d     = dp_in;
                disp_lz_d     = lz_en;
            end else if (pend_valid_q) begin
                disp_digits_d = pend_digits_q;
                disp_dp_d     = pend_dp_q;
                disp_lz_d     = pend_lz_q;
            end
        end else if (load) begin
            pend_digits_d = digits_in;
            pend_dp_d     = dp_in;
            pend_lz_d     = lz_en;
            pend_valid_d  = 1'b1;
        end
    end

    // A digit above 0 is suppressed when it and all higher digits are zero.
    always_comb begin
        supp       = '0;
        zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            if (disp_digits_d[4*i +: 4] != 4'd0) begin
                zero_above = 1'b0;
            end
            supp[i] = disp_lz_d && zero_above;
        end
    end

    // Outputs are evaluated on the post-edge counter and display values.
    always_comb begin
        bcd_d  = 4'd0;
        dp_d   = 1'b0;
        onehot = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (index_d == IW'(i)) begin
                bcd_d     = disp_digits_d[4*i +: 4];
                dp_d      = disp_dp_d[i];
                onehot[i] = !supp[i] && (32'(presc_d) >= BLANK_CYCLES);
            end
        end
        en_d         = onehot ^ EN_IDLE;
        blank_d      = ~|onehot;
        frame_done_d = (presc_d == PRESC_MAX) && (index_d == IDX_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            index_q       <= '0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_lz_q     <= 1'b0;
            pend_valid_q  <= 1'b0;
            disp_digits_q <= '0;
            disp_dp_q     <= '0;
            disp_lz_q     <= 1'b0;
            bcd_q         <= 4'd0;
            dp_q          <= 1'b0;
            en_q          <= EN_IDLE;
            blank_q       <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            index_q       <= index_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_lz_q     <= pend_lz_d;
            pend_valid_q  <= pend_valid_d;
            disp_digits_q <= disp_digits_d;
            disp_dp_q     <= disp_dp_d;
            disp_lz_q     <= disp_lz_d;
            bcd_q         <= bcd_d;
            dp_q          <= dp_d;
            en_q          <= en_d;
            blank_q       <= blank_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign dp_out     = dp_q;
    assign digit_en   = en_q;
    assign blank      = blank_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: randomized loads against a frame-level model.
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int CD = 4;
    localparam int FL = ND * CD;
    localparam logic [10:0] RST_VEC = {4'd0, 1'b0, 4'b1111, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_en = 1'b0;
    logic [3:0]  bcd_out;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        blank;
    logic        frame_done;
    logic [10:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: position within time since reset release, last loaded data, data shown this frame.
    int          m_pos;
    logic [15:0] m_last_d, m_frm_d;
    logic [3:0]  m_last_dp, m_frm_dp;
    logic        m_last_lz, m_frm_lz;

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(1), .EN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .lz_en(lz_en), .bcd_out(bcd_out), .dp_out(dp_out), .digit_en(digit_en),
        .blank(blank), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    assign obs = {bcd_out, dp_out, digit_en, blank, frame_done};

    task automatic model_reset();
        m_pos = 0;
        m_last_d = '0; m_last_dp = '0; m_last_lz = 1'b0;
        m_frm_d  = '0; m_frm_dp  = '0; m_frm_lz  = 1'b0;
    endtask

    // Expected {bcd, dp, digit_en, blank, frame_done} for the current position.
    function automatic logic [10:0] model_out();
        int slot, sub;
        logic [3:0] dig, en;
        logic supp, act;
        slot = (m_pos / CD) % ND;
        sub  = m_pos % CD;
        dig  = 4'(m_frm_d >> (4 * slot));
        supp = m_frm_lz && (slot > 0) && ((m_frm_d >> (4 * slot)) == 16'd0);
        act  = (sub >= 1) && !supp;
        en   = act ? ~(4'b0001 << slot) : 4'b1111;
        return {dig, m_frm_dp[slot], en, !act, (m_pos % FL) == FL - 1};
    endfunction

    // One clock: drive inputs for the current cycle, advance the model past the edge.
    task automatic tick(input bit ld, input logic [15:0] d, input logic [3:0] dp, input bit lz);
        load      = ld;
        digits_in = ld ? d : 16'($urandom);
        dp_in     = ld ? dp : 4'($urandom);
        lz_en     = ld ? lz : 1'($urandom);
        @(posedge clk);
        if (ld) begin
            m_last_d = d; m_last_dp = dp; m_last_lz = lz;
        end
        m_pos++;
        if (m_pos % FL == 0) begin
            m_frm_d = m_last_d; m_frm_dp = m_last_dp; m_frm_lz = m_last_lz;
        end
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        int first_fd;
        first_fd = -1;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== RST_VEC) begin
            n_fail++; $display("FAIL reset_async got=%h exp=%h", obs, RST_VEC);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (obs !== RST_VEC) begin
            n_fail++; $display("FAIL reset_held got=%h exp=%h", obs, RST_VEC);
        end
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 40; k++) begin
            tick(1'b0, '0, '0, 1'b0);
            if (frame_done === 1'b1 && first_fd < 0) first_fd = m_pos;
            n_tests++;
            if (obs !== model_out()) begin
                n_fail++; $display("FAIL reset_scan pos=%0d got=%h exp=%h", m_pos, obs, model_out());
            end
        end
        n_tests++;
        if (first_fd !== FL - 1) begin
            n_fail++; $display("FAIL first_frame_done got=%0d exp=%0d", first_fd, FL - 1);
        end
    endtask

    task automatic test_normal_scan();
        tick(1'b1, 16'h1234, 4'b0100, 1'b0);
        for (int k = 0; k < 2 * FL + 3; k++) begin
            tick(1'b0, '0, '0, 1'b0);
            n_tests++;
            if (obs !== model_out()) begin
                n_fail++; $display("FAIL normal_scan pos=%0d got=%h exp=%h", m_pos, obs, model_out());
            end
        end
    endtask

    task automatic test_leading_zeros();
        int en_cnt;
        en_cnt = 0;
        tick(1'b1, 16'h0050, 4'b0000, 1'b1);
        for (int k = 0; k < 2 * FL; k++) begin
            tick(1'b0, '0, '0, 1'b0);
            n_tests++;
            if (obs !== model_out()) begin
                n_fail++; $display("FAIL lz_0050 pos=%0d got=%h exp=%h", m_pos, obs, model_out());
            end
        end
        tick(1'b1, 16'h0000, 4'b0000, 1'b1);
        for (int k = 0; k < 2 * FL; k++) begin
            tick(1'b0, '0, '0, 1'b0);
            if (k >= FL && digit_en !== 4'b1111) en_cnt++;
            n_tests++;
            if (obs !== model_out()) begin
                n_fail++; $display("FAIL lz_0000 pos=%0d got=%h exp=%h", m_pos, obs, model_out());
            end
        end
        n_tests++;
        if (en_cnt !== CD - 1) begin
            n_fail++; $display("FAIL lz_0000_enabled_cycles got=%0d exp=%0d", en_cnt, CD - 1);
        end
    endtask

    task automatic test_tear_free();
        tick(1'b1, 16'h1234, 4'b0000, 1'b0);
        for (int k = 0; k < 3 * FL && !(m_frm_d == 16'h1234 && m_pos % FL == 5); k++) begin
            tick(1'b0, '0, '0, 1'b0);
        end
        tick(1'b1, 16'h1111, 4'b0001, 1'b0);
        n_tests++;
        if (obs !== model_out()) begin
            n_fail++; $display("FAIL tear_load1 pos=%0d got=%h exp=%h", m_pos, obs, model_out());
        end
        while (m_pos % FL != 9) tick(1'b0, '0, '0, 1'b0);
        tick(1'b1, 16'h2222, 4'b0010, 1'b0);
        for (int k = 0; k < 2 * FL; k++) begin
            tick(1'b0, '0, '0, 1'b0);
            n_tests++;
            if (obs !== model_out()) begin
                n_fail++; $display("FAIL tear_free pos=%0d got=%h exp=%h", m_pos, obs, model_out());
            end
        end
    endtask

    task automatic test_boundary_load();
        while (m_pos % FL != FL - 1) tick(1'b0, '0, '0, 1'b0);
        n_tests++;
        if (frame_done !== 1'b1) begin
            n_fail++; $display("FAIL boundary_fd got=%b exp=1", frame_done);
        end
        tick(1'b1, 16'h9876, 4'b1001, 1'b0);
        for (int k = 0; k < FL; k++) begin
            n_tests++;
            if (obs !== model_out()) begin
                n_fail++; $display("FAIL boundary_load pos=%0d got=%h exp=%h", m_pos, obs, model_out());
            end
            tick(1'b0, '0, '0, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        for (int k = 0; k < 400; k++) begin
            for (int n = 0; n < ND; n++) begin
                d[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            end
            tick($urandom_range(0, 7) == 0, d, 4'($urandom), 1'($urandom));
            n_tests++;
            if (obs !== model_out()) begin
                n_fail++; $display("FAIL random pos=%0d got=%h exp=%h", m_pos, obs, model_out());
            end
        end
    endtask

    task automatic test_reset_midslot();
        tick(1'b1, 16'h5678, 4'b1111, 1'b0);
        while (m_pos % FL < CD || m_pos % CD != 2) tick(1'b0, '0, '0, 1'b0);
        tick(1'b1, 16'hABCD, 4'b0110, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== RST_VEC) begin
            n_fail++; $display("FAIL reset_midslot got=%h exp=%h", obs, RST_VEC);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < FL + 4; k++) begin
            tick(1'b0, '0, '0, 1'b0);
            n_tests++;
            if (obs !== model_out()) begin
                n_fail++; $display("FAIL after_reset pos=%0d got=%h exp=%h", m_pos, obs, model_out());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_normal_scan();
        test_leading_zeros();
        test_tear_free();
        test_boundary_load();
        test_random();
        test_reset_midslot();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
